ctrl_fifo_unpack: RTL and testbench



---
 rtl/ctrl_fifo_pkg.sv | 15 +
 rtl/fifo_word_ram.sv | 31 +++
 rtl/ctrl_fifo_unpack.sv | 101 ++++++++++
 tb/tb_ctrl_fifo_unpack.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_fifo_pkg.sv
// Shared definitions for the control FIFO family (the packing and unpacking
// variants). It holds the word and byte geometry and the level-width helper.
package ctrl_fifo_pkg;

  localparam int unsigned WIDE_W         = 256;
  localparam int unsigned NARROW_W       = 8;
  localparam int unsigned BYTES_PER_WORD = 32;
  localparam int unsigned BIDX_W         = 5;

  // Number of bits needed to hold a byte level of 0..depth_words*32.
  function automatic int unsigned lvl_width(input int unsigned depth_words);
    return $clog2(depth_words * BYTES_PER_WORD + 1);
  endfunction

endpackage

// File: rtl/fifo_word_ram.sv
// Simple dual-port word store with a synchronous write and an asynchronous read.
// It has no reset, so stored contents are only meaningful where the owning
// pointers say so.
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write word
//   i_raddr : read address
//   o_rdata : combinational read word
module fifo_word_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned W     = 256
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ctrl_fifo_unpack.sv
// Wide-to-narrow control FIFO. It accepts 256-bit words and delivers them one
// byte at a time, least-significant byte first, with first-word-fall-through
// on the byte side.
//   clk, rst        : single clock, synchronous active-high reset
//   din, wrreq      : word write (accepted when ~full)
//   full/almost_full: word-count flags
//   dout, rdreq     : head byte (0 when empty) and pop request
//   empty/almost_empty, rd_water_level : byte-level flags and level
//   wr_overflow / rd_underflow : one-cycle pulses for rejected requests
module ctrl_fifo_unpack
  import ctrl_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH_WORDS = 8,
  parameter  int unsigned AF_MARGIN   = 1,
  parameter  int unsigned AE_THRESH   = 4,
  localparam int unsigned LVL_W       = lvl_width(DEPTH_WORDS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDE_W-1:0]   din,
  input  logic                wrreq,
  output logic                full,
  output logic                almost_full,
  output logic [NARROW_W-1:0] dout,
  input  logic                rdreq,
  output logic                empty,
  output logic                almost_empty,
  output logic [LVL_W-1:0]    rd_water_level,
  output logic                wr_overflow,
  output logic                rd_underflow
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(DEPTH_WORDS + 1);

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [BIDX_W-1:0] r_byte_idx;
  logic [CW-1:0]     r_word_cnt;
  logic              r_wr_ovf;
  logic              r_rd_udf;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_free;
  logic [LVL_W-1:0]  w_level;
  logic [WIDE_W-1:0] w_head;
  logic [NARROW_W-1:0] w_head_byte;

  // Bytes still readable: whole stored words minus those already taken from the head.
  assign w_level = LVL_W'({r_word_cnt, {BIDX_W{1'b0}}}) - LVL_W'(r_byte_idx);

  assign full         = (r_word_cnt == CW'(DEPTH_WORDS));
  assign almost_full  = (r_word_cnt >= CW'(DEPTH_WORDS - AF_MARGIN));
  assign empty        = (w_level == '0);
  assign almost_empty = (w_level <= LVL_W'(AE_THRESH));

  assign w_wr_acc = wrreq & ~full;
  assign w_rd_acc = rdreq & ~empty;
  // Popping the last byte of the head word releases that word slot.
  assign w_free   = w_rd_acc & (r_byte_idx == '1);

  fifo_word_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW),
    .W     (WIDE_W)
  ) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (din),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  assign w_head_byte    = w_head[{r_byte_idx, 3'b000} +: NARROW_W];
  assign dout           = empty ? '0 : w_head_byte;
  assign rd_water_level = w_level;
  assign wr_overflow    = r_wr_ovf;
  assign rd_underflow   = r_rd_udf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_byte_idx <= '0;
      r_word_cnt <= '0;
      r_wr_ovf   <= 1'b0;
      r_rd_udf   <= 1'b0;
    end else begin
      r_wr_ovf <= wrreq & full;
      r_rd_udf <= rdreq & empty;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_byte_idx <= r_byte_idx + BIDX_W'(1);
      if (w_free)   r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_acc && !w_free)      r_word_cnt <= r_word_cnt + CW'(1);
      else if (!w_wr_acc && w_free) r_word_cnt <= r_word_cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_ctrl_fifo_unpack.sv
module tb_ctrl_fifo_unpack;

  localparam int DEPTH = 8;
  localparam int AFM   = 1;
  localparam int AET   = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] din;
  logic         wrreq, rdreq;
  logic         full, almost_full, empty, almost_empty;
  logic [7:0]   dout;
  logic [8:0]   rd_water_level;
  logic         wr_overflow, rd_underflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ctrl_fifo_unpack #(
    .DEPTH_WORDS (DEPTH),
    .AF_MARGIN   (AFM),
    .AE_THRESH   (AET)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .din            (din),
    .wrreq          (wrreq),
    .full           (full),
    .almost_full    (almost_full),
    .dout           (dout),
    .rdreq          (rdreq),
    .empty          (empty),
    .almost_empty   (almost_empty),
    .rd_water_level (rd_water_level),
    .wr_overflow    (wr_overflow),
    .rd_underflow   (rd_underflow)
  );

  // Reference model: the FIFO viewed as a plain queue of bytes.
  logic [7:0] mq[$];
  bit m_ovf, m_udf;

  function automatic logic [255:0] mkword(input int tag);
    logic [255:0] w;
    for (int k = 0; k < 32; k++) w[8*k +: 8] = 8'(tag * 32 + k);
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int lvl, wc;
    lvl = mq.size();
    wc  = (lvl + 31) / 32;
    chk("dout",         int'(dout), (lvl > 0) ? int'(mq[0]) : 0);
    chk("empty",        int'(empty), int'(lvl == 0));
    chk("full",         int'(full), int'(wc == DEPTH));
    chk("almost_full",  int'(almost_full), int'(wc >= DEPTH - AFM));
    chk("almost_empty", int'(almost_empty), int'(lvl <= AET));
    chk("level",        int'(rd_water_level), lvl);
    chk("wr_overflow",  int'(wr_overflow), int'(m_ovf));
    chk("rd_underflow", int'(rd_underflow), int'(m_udf));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, compare.
  task automatic step(input bit r, input bit w, input bit rd, input logic [255:0] d);
    bit mfull;
    rst = r; wrreq = w; rdreq = rd; din = d;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      mfull = ((mq.size() + 31) / 32) == DEPTH;
      m_ovf = w && mfull;
      m_udf = rd && (mq.size() == 0);
      if (rd && mq.size() > 0) void'(mq.pop_front());
      if (w && !mfull)
        for (int k = 0; k < 32; k++) mq.push_back(d[8*k +: 8]);
    end
    #1;
    check_model();
  endtask

  typedef struct {
    bit rst, wr, rd;
    int tag;
    bit e_empty, e_full;
    int e_lvl, e_dout;
    bit e_ovf, e_udf;
  } vec_t;

  vec_t vt[7];

  initial begin
    rst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; din = '0;

    vt[0] = '{1, 0, 0, 0, 1, 0, 0,  0, 0, 0};  // reset
    vt[1] = '{0, 0, 1, 0, 1, 0, 0,  0, 0, 1};  // read while empty
    vt[2] = '{0, 0, 0, 0, 1, 0, 0,  0, 0, 0};  // pulse drops
    vt[3] = '{0, 1, 0, 0, 0, 0, 32, 0, 0, 0};  // fall-through
    vt[4] = '{0, 0, 1, 0, 0, 0, 31, 1, 0, 0};
    vt[5] = '{0, 1, 1, 1, 0, 0, 62, 2, 0, 0};  // read + write same cycle
    vt[6] = '{1, 1, 1, 2, 1, 0, 0,  0, 0, 0};  // reset wins over requests

    #2;
    for (int i = 0; i < 7; i++) begin
      step(vt[i].rst, vt[i].wr, vt[i].rd, mkword(vt[i].tag));
      chk($sformatf("vec%0d_empty", i), int'(empty), int'(vt[i].e_empty));
      chk($sformatf("vec%0d_full", i),  int'(full), int'(vt[i].e_full));
      chk($sformatf("vec%0d_lvl", i),   int'(rd_water_level), vt[i].e_lvl);
      chk($sformatf("vec%0d_dout", i),  int'(dout), vt[i].e_dout);
      chk($sformatf("vec%0d_ovf", i),   int'(wr_overflow), int'(vt[i].e_ovf));
      chk($sformatf("vec%0d_udf", i),   int'(rd_underflow), int'(vt[i].e_udf));
    end
    chk("reset_ae", int'(almost_empty), 1);
    chk("reset_af", int'(almost_full), 0);

    // Single word drained byte by byte
    step(0, 1, 0, mkword(0));
    for (int k = 0; k < 32; k++) begin
      chk("single_byte", int'(dout), k);
      step(0, 0, 1, '0);
    end
    chk("single_empty", int'(empty), 1);

    // Fill to full, then an overflowing write whose data must never appear
    for (int t = 0; t < DEPTH; t++) begin
      step(0, 1, 0, mkword(t));
      if (t == DEPTH - 2) begin
        chk("af_after_7", int'(almost_full), 1);
        chk("full_after_7", int'(full), 0);
      end
    end
    chk("full_after_8", int'(full), 1);
    chk("level_full", int'(rd_water_level), 256);
    step(0, 1, 0, {32{8'hEE}});
    chk("ovf_pulse", int'(wr_overflow), 1);
    step(0, 0, 0, '0);
    chk("ovf_one_cycle", int'(wr_overflow), 0);

    // Stream all 256 bytes without gaps; byte i of the stream equals i
    for (int i = 0; i < 256; i++) begin
      chk("stream_byte", int'(dout), i);
      step(0, 0, 1, '0);
      if (i == 31) chk("full_drop_after_31", int'(full), 0);
      if (i == 251) chk("ae_at_4", int'(almost_empty), 1);
      if (i == 250) chk("ae_at_5", int'(almost_empty), 0);
    end
    chk("stream_empty", int'(empty), 1);

    // Concurrent: two words resident, a new word lands on every 32nd read
    step(0, 1, 0, mkword(3));
    step(0, 1, 0, mkword(4));
    for (int i = 0; i < 32 * 12; i++) begin
      step(0, (i % 32) == 31, 1, mkword(5 + i / 32));
      chk("conc_level_range", int'(rd_water_level > 32 && rd_water_level <= 64), 1);
    end

    // Reset mid-stream at level 100, then one clean word
    step(1, 0, 0, '0);
    for (int t = 0; t < 4; t++) step(0, 1, 0, mkword(t));
    for (int i = 0; i < 28; i++) step(0, 0, 1, '0);
    chk("mid_level_100", int'(rd_water_level), 100);
    step(1, 1, 1, mkword(6));
    chk("mid_reset_level", int'(rd_water_level), 0);
    chk("mid_reset_dout", int'(dout), 0);
    step(0, 1, 0, mkword(5));
    for (int k = 0; k < 32; k++) begin
      chk("post_reset_byte", int'(dout), 5 * 32 + k);
      step(0, 0, 1, '0);
    end
    chk("post_reset_empty", int'(empty), 1);

    // Randomized traffic in phases of varying write pressure
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 600; c++) begin
        step($urandom_range(0, 299) == 0,
             $urandom_range(0, 15) < (p * 2 + 1),
             $urandom_range(0, 3) != 0,
             {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
